// File: rtl/wbcsr_bridge_pkg.sv
// Shared CSR-bus definitions: bridge state encoding and default CSR address width.
package wbcsr_bridge_pkg;

  localparam int CSR_AW_DEFAULT = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

endpackage

// File: rtl/wbcsr_bridge.sv
// Wishbone slave to single-cycle CSR bus bridge: write acks in cycle 2, read acks in cycle READ_WAIT+1.
// One access in flight; no accept during ACK, so the master sees backpressure until the cycle after ack.
module wbcsr_bridge
  import wbcsr_bridge_pkg::*;
#(
  parameter int CSR_AW    = CSR_AW_DEFAULT,
  parameter int READ_WAIT = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic [CSR_AW-1:0] csr_a,
  output logic              csr_we,
  output logic [31:0]       csr_do,
  input  logic [31:0]       csr_di
);

  if (READ_WAIT < 1 || READ_WAIT > 7) begin : g_bad_read_wait
    $error("READ_WAIT must be within 1..7");
  end

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              we_q, we_d;
  logic [CSR_AW-1:0] csr_a_q, csr_a_d;
  logic [31:0]       csr_do_q, csr_do_d;
  logic [31:0]       dat_q, dat_d;
  logic              req;

  // Byte-lane and out-of-window address bits are intentionally ignored.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:CSR_AW+2], wb_adr_i[1:0]};

  // The matrix decodes cyc only; stb may belong to another slave's cycle.
  assign req = wb_cyc_i & wb_stb_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    we_d     = 1'b0;
    csr_a_d  = csr_a_q;
    csr_do_d = csr_do_q;
    dat_d    = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          csr_a_d  = wb_adr_i[CSR_AW+1:2];
          csr_do_d = wb_dat_i;
          if (wb_we_i) begin
            state_d = ST_WRITE;
            we_d    = 1'b1;
          end else begin
            state_d = ST_READ;
            cnt_d   = 3'(READ_WAIT);
          end
        end
      end
      ST_WRITE: begin
        // The strobe already went out; an abandoned cycle just loses its ack.
        ack_d   = wb_cyc_i;
        state_d = wb_cyc_i ? ST_ACK : ST_IDLE;
      end
      ST_READ: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 3'd1) begin
          dat_d   = csr_di;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      ack_q    <= 1'b0;
      we_q     <= 1'b0;
      csr_a_q  <= '0;
      csr_do_q <= 32'd0;
      dat_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      we_q     <= we_d;
      csr_a_q  <= csr_a_d;
      csr_do_q <= csr_do_d;
      dat_q    <= dat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign csr_we   = we_q;
  assign csr_a    = csr_a_q;
  assign csr_do   = csr_do_q;

endmodule

// File: tb/tb_wbcsr_bridge.sv
// Bench for wbcsr_bridge: random Wishbone traffic against a word-array model, plus abort, reset and READ_WAIT sweep.
module tb_wbcsr_bridge;

  localparam int RW = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_do, csr_di;

  always #5 sys_clk = ~sys_clk;

  wbcsr_bridge u_dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_we_i (wb_we_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_do  (csr_do),
    .csr_di  (csr_di)
  );

  // Extra instances for the READ_WAIT extremes; they share stb/we/adr but have their own cyc.
  logic        sw_cyc [2];
  logic        sw_ack [2];
  logic        sw_we  [2];
  logic [31:0] sw_dat [2];
  logic [31:0] sw_do  [2];
  logic [13:0] sw_a   [2];
  logic [31:0] sw_di;

  wbcsr_bridge #(.READ_WAIT(1)) u_rw1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(sw_dat[0]), .wb_we_i(wb_we_i), .wb_cyc_i(sw_cyc[0]), .wb_stb_i(wb_stb_i),
    .wb_ack_o(sw_ack[0]), .csr_a(sw_a[0]), .csr_we(sw_we[0]), .csr_do(sw_do[0]), .csr_di(sw_di)
  );

  wbcsr_bridge #(.READ_WAIT(7)) u_rw7 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(sw_dat[1]), .wb_we_i(wb_we_i), .wb_cyc_i(sw_cyc[1]), .wb_stb_i(wb_stb_i),
    .wb_ack_o(sw_ack[1]), .csr_a(sw_a[1]), .csr_we(sw_we[1]), .csr_do(sw_do[1]), .csr_di(sw_di)
  );

  // Register bank: registered read data one cycle after csr_a, write on csr_we.
  logic [31:0] bank_mem [0:16383] = '{default: 32'h0};
  always @(posedge sys_clk) begin
    if (csr_we) bank_mem[csr_a] <= csr_do;
    csr_di <= bank_mem[csr_a];
  end

  // Reference: what a master expects to read back from each CSR word.
  logic [31:0] model_mem [int];
  logic [31:0] last_rd;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic int csr_index(input logic [31:0] adr);
    return int'((adr / 32'd4) % 32'd16384);
  endfunction

  function automatic logic [31:0] model_rd(input int idx);
    return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  logic rst_seen;
  logic ack_prev = 1'b0;
  always @(posedge sys_clk) rst_seen <= sys_rst;
  always @(negedge sys_clk) begin
    if (rst_seen) chk("we_after_rst", 32'(csr_we), 32'h0);
    if (wb_ack_o) chk("ack_width", 32'(ack_prev), 32'h0);
    ack_prev <= wb_ack_o;
  end

  // Called at a negedge; b2b means stb was held through the previous ack.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input bit b2b, input bit hold);
    int n;
    int pulses;
    int exp_lat;
    bit done;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    n = 0;
    pulses = 0;
    done = 1'b0;
    exp_lat = (we ? 2 : RW + 1) + (b2b ? 1 : 0);
    while (!done && n < 20) begin
      @(negedge sys_clk);
      n++;
      if (csr_we) begin
        pulses++;
        chk("we_addr", 32'(csr_a), 32'(csr_index(adr)));
        chk("we_data", csr_do, dat);
      end
      if (wb_ack_o) done = 1'b1;
    end
    if (done) chk("latency", 32'(n), 32'(exp_lat));
    else chk("timeout", 32'(n), 32'(exp_lat));
    chk("we_pulses", 32'(pulses), we ? 32'd1 : 32'd0);
    if (we) begin
      model_mem[csr_index(adr)] = dat;
    end else begin
      chk("rdata", wb_dat_o, model_rd(csr_index(adr)));
      last_rd = model_rd(csr_index(adr));
    end
    if (!hold) begin
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge sys_clk);
      chk("idle_quiet", 32'({wb_ack_o, csr_we}), 32'h0);
      chk("dat_hold", wb_dat_o, last_rd);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_csr_a"}, 32'(csr_a), 32'h0);
    chk({tag, "_csr_do"}, csr_do, 32'h0);
    chk({tag, "_csr_we"}, 32'(csr_we), 32'h0);
    chk({tag, "_ack"}, 32'(wb_ack_o), 32'h0);
    chk({tag, "_dat_o"}, wb_dat_o, 32'h0);
  endtask

  initial begin
    bit          hold, prev_hold;
    logic        we;
    int          idx;
    logic [31:0] adr, r, qa;

    sys_rst  = 1'b1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = 32'h0;
    wb_dat_i = 32'h0;
    sw_cyc[0] = 1'b0;
    sw_cyc[1] = 1'b0;
    sw_di    = 32'h0;
    last_rd  = 32'h0;
    repeat (3) @(negedge sys_clk);
    chk_reset_vals("reset");
    sys_rst = 1'b0;
    idle(2);

    // Directed write, then directed read at the default wait.
    wb_xfer(1'b1, 32'h6000_1004, 32'hDEAD_BEEF, 1'b0, 1'b0);
    idle(1);
    wb_xfer(1'b1, 32'h6000_0008, 32'h1234_5678, 1'b0, 1'b0);
    idle(2);
    wb_xfer(1'b0, 32'h6000_0008, 32'h0, 1'b0, 1'b0);
    chk("dir_read", wb_dat_o, 32'h1234_5678);
    idle(1);

    // Back-to-back with stb held through the first ack.
    wb_xfer(1'b1, 32'h6000_0010, 32'hA5A5_0001, 1'b0, 1'b1);
    wb_xfer(1'b0, 32'h6000_0010, 32'h0, 1'b1, 1'b0);
    idle(1);

    // Random traffic over a small window of CSR words.
    prev_hold = 1'b0;
    for (int t = 0; t < 80; t++) begin
      we   = 1'($urandom_range(0, 1));
      idx  = $urandom_range(0, 15);
      r    = $urandom();
      adr  = (r & 32'hFFFF_0003) | (32'(idx) << 2);
      hold = (t != 79) && ($urandom_range(0, 3) == 0);
      wb_xfer(we, adr, $urandom(), prev_hold, hold);
      if (!hold) idle($urandom_range(1, 3));
      prev_hold = hold;
    end

    // Read abandoned in its first READ cycle, then an immediate write must start cleanly.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h6000_0020;
    @(negedge sys_clk);
    wb_cyc_i = 1'b0;
    @(negedge sys_clk);
    chk("rd_abort_ack", 32'(wb_ack_o), 32'h0);
    chk("rd_abort_dat", wb_dat_o, last_rd);
    wb_stb_i = 1'b0;
    wb_xfer(1'b1, 32'h6000_0024, 32'hC0FF_EE00, 1'b0, 1'b0);
    idle(2);

    // Write abandoned after its strobe: strobe lands, no ack.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h6000_0028; wb_dat_i = 32'h0BAD_F00D;
    @(negedge sys_clk);
    chk("wr_abort_we", 32'(csr_we), 32'h1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    model_mem[csr_index(32'h6000_0028)] = 32'h0BAD_F00D;
    idle(4);

    // Reset during WRITE, held one more cycle with a request pending.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h6000_0014; wb_dat_i = 32'h5555_AAAA;
    @(negedge sys_clk);
    chk("rst_wr_we", 32'(csr_we), 32'h1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk_reset_vals("rst_mid");
    @(negedge sys_clk);
    chk("rst_req_quiet", 32'({wb_ack_o, csr_we}), 32'h0);
    sys_rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    model_mem[csr_index(32'h6000_0014)] = 32'h5555_AAAA;
    last_rd = 32'h0;
    idle(3);
    wb_xfer(1'b0, 32'h6000_0014, 32'h0, 1'b0, 1'b0);
    idle(1);
    wb_xfer(1'b0, 32'h6000_0028, 32'h0, 1'b0, 1'b0);
    idle(1);

    // stb without cyc belongs to another slave: nothing may move.
    qa = 32'(csr_a);
    for (int i = 0; i < 20; i++) begin
      wb_cyc_i = 1'b0; wb_stb_i = 1'b1; wb_we_i = 1'($urandom_range(0, 1));
      wb_adr_i = $urandom(); wb_dat_i = $urandom();
      @(negedge sys_clk);
      chk("qual_quiet", 32'({wb_ack_o, csr_we}), 32'h0);
      chk("qual_csr_a", 32'(csr_a), qa);
    end
    wb_stb_i = 1'b0;
    idle(1);

    // READ_WAIT extremes: ack in cycle 2 and cycle 8.
    for (int k = 0; k < 2; k++) begin
      int  n;
      int  we_seen;
      bit  done;
      sw_di = $urandom();
      wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_adr_i = 32'h6000_0100;
      sw_cyc[k] = 1'b1;
      n = 0; we_seen = 0; done = 1'b0;
      while (!done && n < 20) begin
        @(negedge sys_clk);
        n++;
        if (sw_we[k]) we_seen++;
        if (sw_ack[k]) done = 1'b1;
      end
      if (done) chk("sweep_latency", 32'(n), (k == 0) ? 32'd2 : 32'd8);
      else chk("sweep_timeout", 32'(n), (k == 0) ? 32'd2 : 32'd8);
      chk("sweep_data", sw_dat[k], sw_di);
      chk("sweep_csr_a", 32'(sw_a[k]), 32'h40);
      chk("sweep_we", 32'(we_seen), 32'h0);
      sw_cyc[k] = 1'b0; wb_stb_i = 1'b0;
      repeat (2) @(negedge sys_clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wbcsr_bridge.md
# wbcsr_bridge

Wishbone slave that converts bus-matrix transactions into accesses on the narrow, single-cycle CSR bus shared by all peripheral register banks. Sits directly downstream of the 5-master / 7-slave bus matrix on the slave port decoded for the CSR region. It drives the CSR address, write strobe and write data from registers. It returns read data and a single-cycle `wb_ack_o` after a fixed, parameterised latency.

## Interface

Parameters:

- `CSR_AW`, default 14: CSR address width; `csr_a = wb_adr_i[CSR_AW+1:2]`.
- `READ_WAIT`, default 2: cycles between `csr_a` becoming valid and `csr_di` being sampled. Legal range is 1..7.

Ports. One clock; reset is synchronous and active-high.

- `sys_clk`, in, 1: system clock; all state changes on its rising edge.
- `sys_rst`, in, 1: synchronous active-high reset.
- `wb_adr_i`, in, 32: byte address; only bits `[CSR_AW+1:2]` are used.
- `wb_dat_i`, in, 32: write data.
- `wb_dat_o`, out, 32: read data, registered.
- `wb_we_i`, in, 1: 1 = write.
- `wb_cyc_i`, in, 1: cycle, already gated by the matrix address decoder.
- `wb_stb_i`, in, 1: strobe. It is NOT decoded by the matrix, so it must be qualified with `wb_cyc_i`.
- `wb_ack_o`, out, 1: transfer acknowledge, registered, one cycle wide.
- `csr_a`, out, `CSR_AW`: CSR address, registered.
- `csr_we`, out, 1: CSR write strobe, registered.
- `csr_do`, out, 32: CSR write data, registered.
- `csr_di`, in, 32: OR of all CSR banks' read data; banks register it one cycle after `csr_a`.

## Operation

States: IDLE, WRITE, READ, ACK. Binary-encoded with a 3-bit wait counter `cnt`.

- **IDLE:** `req = wb_cyc_i & wb_stb_i`. On `req`:
  - load `csr_a <= wb_adr_i[CSR_AW+1:2]` and `csr_do <= wb_dat_i`;
  - if `wb_we_i`, go to WRITE and set `csr_we <= 1`;
  - otherwise go to READ and set `cnt <= READ_WAIT`.
- **WRITE:** `csr_we = 1` for exactly this one cycle. Next state is ACK with `csr_we <= 0` and `wb_ack_o <= 1`.
- **READ:** `csr_we = 0`.
  - If `cnt == 1`: `wb_dat_o <= csr_di`, `wb_ack_o <= 1`, go to ACK.
  - Otherwise `cnt <= cnt - 1`.
- **ACK:** `wb_ack_o = 1` for exactly this cycle. Next state is IDLE with `wb_ack_o <= 0`. `req` is ignored in ACK; no back-to-back accept from ACK.

Held values:

- `csr_a` and `csr_do` hold their last value outside IDLE-accept. Banks ignore `csr_a` unless `csr_we` is set or they are being read.
- `wb_dat_o` holds its last captured value until the next read capture.
- `wb_sel_i` and `wb_cti_i` are not used. All CSR accesses are full 32-bit and single-beat. Bursts are handled as a sequence of single accesses, each acked separately.

## Timing

Reset values (after any `sys_rst` edge):

- state = IDLE, `cnt = 0`;
- `wb_ack_o = 0`, `csr_we = 0`;
- `csr_a = 0`, `csr_do = 0`, `wb_dat_o = 0`.

Latency, with cycle 0 as the IDLE cycle where `req` is sampled high:

- **Write:** `csr_we` high in cycle 1; `wb_ack_o` high in cycle 2. Three cycles per write.
- **Read:** `csr_a` valid from cycle 1. `csr_di` is sampled at the end of cycle `READ_WAIT`. `wb_ack_o` and `wb_dat_o` are valid in cycle `READ_WAIT+1`. Default: ack in cycle 3.
- **Next accept:** earliest is the cycle after ACK. A master holding `stb` through ACK and dropping it on the ack edge causes no duplicate access.

Abort and reset rules:

- **`wb_cyc_i` deasserted in READ:** return to IDLE next edge. No ack; `wb_dat_o` unchanged.
- **`wb_cyc_i` deasserted in WRITE:** the `csr_we` pulse already issued completes. Go to IDLE next edge, no ack.
- **`wb_cyc_i` deasserted in ACK:** the ack is still driven for its one cycle. The matrix discards it harmlessly.
- **`sys_rst` mid-transaction:** abort. Outputs take their reset values at that edge and no ack is ever issued for the aborted cycle. `csr_we` must never be high in the cycle after a reset edge.
- **`sys_rst` with `req` high:** reset wins; no access starts that edge.

## Structure

- State encodings (IDLE=0, WRITE=1, READ=2, ACK=3) and the default `CSR_AW` go in the shared `conbus` defines header. The CSR bank modules reuse `CSR_AW`.
- Single module; no sub-module is natural. The wait counter stays inline.

## Test plan

- **Write:** after reset, write `adr=0x6000_1004`, `dat=0xDEADBEEF`.
  - Cycle 1: `csr_a=0x0401`, `csr_do=0xDEADBEEF`, `csr_we=1`.
  - Cycle 2: `csr_we=0`, `wb_ack_o=1`.
  - Exactly one `csr_we` pulse.
- **Read, default wait:** read `adr=0x6000_0008` with a CSR model returning `0x12345678` one cycle after `csr_a`.
  - `wb_ack_o=1` in cycle 3 with `wb_dat_o=0x12345678`.
  - `csr_we` stays 0 throughout.
- **`READ_WAIT` range:** sweep `READ_WAIT` = 1 and 7. Ack arrives in cycle 2 and cycle 8 respectively, with the correct data.
- **Back-to-back:** write then read with `stb` held continuously.
  - Second access accepted in the cycle after the first ack.
  - Two acks total, never in adjacent cycles.
  - No duplicate `csr_we`.
- **Abort:**
  - Drop `wb_cyc_i` in READ cycle 1: no ack, state is IDLE the next cycle, `wb_dat_o` unchanged.
  - Assert `sys_rst` in WRITE: `csr_we=0` and `wb_ack_o=0` after that edge, and all outputs equal their reset values.
- **Qualification:** `wb_stb_i=1` with `wb_cyc_i=0` (another slave's cycle) for 20 cycles produces no CSR activity and no ack.
